dsp_mac_seq: RTL and testbench
==============================

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 SHALL have parameter LEN, default 4: number of A*B products per dot product (1 to 65535).
REQ-002 SHALL have parameter RES_DEPTH, default 4: result FIFO depth (power of 2, minimum 2).
REQ-003 SHALL have port clk  in  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST_N  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1: operand pair valid.
REQ-006 SHALL have port in_ready  out  1: operand pair accepted when in_valid and in_ready are both high.
REQ-007 SHALL have ports in_a, in_b  in  18 each: unsigned operands.
REQ-008 SHALL have ports dsp_a, dsp_b  out  18 each: drive the slice A and B ports.
REQ-009 SHALL have port dsp_opmode  out  8: drives the slice OPMODE port.
REQ-010 SHALL have port dsp_p  in  48: the slice P output.
REQ-011 SHALL have port dsp_carryout  in  1: the slice CARRYOUT output.
REQ-012 SHALL have port res_valid  out  1: FIFO head valid.
REQ-013 SHALL have port res_ready  in  1: consumer pops the head when res_valid and res_ready are both high.
REQ-014 SHALL have port res_data  out  48: dot-product sum at the FIFO head.
REQ-015 SHALL have port res_ovf  out  1: sticky carry-out flag of the head result.

Function
REQ-016 SHALL drive a slice configured with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYOUTREG=1, CARRYINSEL=OPMODE5, B_INPUT=DIRECT and all CE inputs high; latency from an operand presented in cycle t to P is 3 edges, so P is valid in cycle t+3.
REQ-017 SHALL, on acceptance, drive dsp_a=in_a and dsp_b=in_b combinationally in that cycle; in every non-accept cycle it SHALL drive dsp_a=dsp_b=0 (zero bubble).
REQ-018 SHALL hold an element counter 0..LEN-1 that increments per accepted pair and wraps to 0 after LEN-1; first = (count==0), last = (count==LEN-1); LEN=1 makes every pair both first and last.
REQ-019 SHALL shift a 3-stage tag pipeline {valid, first, last} every cycle; stage 0 is the current accept.
REQ-020 SHALL drive dsp_opmode = 8'h01 (X=M, Z=0, add) when tag stage 1 is valid and first; otherwise 8'h09 (X=M, Z=P, add), so bubbles add zero and preserve P.
REQ-021 SHALL, when tag stage 3 is valid and last, push {dsp_p, ovf_acc | dsp_carryout} into the FIFO at that edge.
REQ-022 SHALL maintain ovf_acc: it becomes dsp_carryout on a stage-3 valid first element, ORs dsp_carryout on other stage-3 valid elements, and clears after a push.
REQ-023 SHALL drive in_ready = (fifo_count + inflight_last) < RES_DEPTH, where inflight_last counts last flags in tag stages 1-3 plus the pair at stage 0 if it is last; the FIFO SHALL never overflow.
REQ-024 SHALL, on a simultaneous push and pop, keep fifo_count unchanged and advance both pointers; a pop on an empty FIFO is ignored.
REQ-025 SHALL keep res_data and res_ovf stable while res_valid=1 and res_ready=0.
REQ-026 SHALL treat arithmetic as unsigned modulo 2^48; overflow is reported only through res_ovf.

Reset
REQ-027 SHALL, while RST_N=0, clear the counter, tags, ovf_acc, FIFO pointers and count; outputs SHALL be in_ready=1 (after release), res_valid=0, res_data=0, res_ovf=0, dsp_a=dsp_b=0, dsp_opmode=8'h09.
REQ-028 SHALL discard a partially accumulated dot on reset; the first pair accepted after release is first.

Verification
REQ-029 LEN=4, back-to-back pairs (1,2),(3,4),(5,6),(7,8) with res_ready=1 -> res_data=100, res_ovf=0, res_valid high in cycle t_last+4 for one cycle.
REQ-030 Same pairs with 2-cycle in_valid gaps -> res_data=100; dsp_opmode=8'h01 exactly once, in the cycle after pair (1,2) is accepted.
REQ-031 Two dots back-to-back, second all (1,1) -> results 100 then 4 in order, no idle cycle needed between dots.
REQ-032 res_ready=0, stream 6 dots of (1,1) -> in_ready drops once 4 results are queued or in flight; releasing res_ready yields six 4s, none lost.
REQ-033 Slice model forces dsp_carryout=1 on the stage-3 cycle of the 2nd element -> that result has res_ovf=1; the next dot has res_ovf=0.
REQ-034 RST_N low for 1 cycle after 2 accepted pairs, then (1,2),(3,4),(5,6),(7,8) -> single result 100, no stale result.

Source files
------------

// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: operand/result handshakes plus DSP slice drive/return, bundled for dsp_mac_seq
// Signals: in_valid/in_ready/in_a/in_b   operand pair handshake (unsigned 18-bit operands)
//          dsp_a/dsp_b/dsp_opmode        drive of the slice A, B and OPMODE ports
//          dsp_p/dsp_carryout            slice P and CARRYOUT outputs
//          res_valid/res_ready/res_data/res_ovf  result FIFO head handshake
// Modports: slave = the sequencer, master = its environment (source, sink and slice)
interface dsp_mac_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;
    logic        dsp_carryout;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        res_ovf;
    modport slave (
        input  in_valid, in_a, in_b, dsp_p, dsp_carryout, res_ready,
        output in_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data, res_ovf
    );
    modport master (
        output in_valid, in_a, in_b, dsp_p, dsp_carryout, res_ready,
        input  in_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: streams operand pairs into a pipelined DSP slice and queues LEN-element dot products
// Ports: clk   single rising-edge clock
//        RST_N asynchronous active-low reset
//        bus   dsp_mac_seq_if.slave: operand handshake, slice drive/return, result FIFO head
module dsp_mac_seq #(
    parameter int LEN       = 4,
    parameter int RES_DEPTH = 4
) (
    input logic          clk,
    input logic          RST_N,
    dsp_mac_seq_if.slave bus
);
    localparam int          AW       = $clog2(RES_DEPTH);
    localparam logic [15:0] LAST_IDX = 16'(LEN - 1);

    logic [15:0]   cnt_q, cnt_d;
    logic [3:1]    vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   fcnt_q, fcnt_d;
    logic [47:0]   mem_data [RES_DEPTH];
    logic          mem_ovf [RES_DEPTH];
    logic          first_now, last_now, acc, push, pop, ovf_now;
    logic [AW+2:0] occ;

    always_comb begin
        first_now      = cnt_q == '0;
        last_now       = cnt_q == LAST_IDX;
        // Results already committed: queued, in the slice pipeline, or about to be started by a last pair.
        occ            = (AW+3)'(fcnt_q) + (AW+3)'(lst_q[1]) + (AW+3)'(lst_q[2]) + (AW+3)'(lst_q[3])
                       + (AW+3)'(last_now);
        bus.in_ready   = occ < (AW+3)'(RES_DEPTH);
        acc            = bus.in_valid & bus.in_ready;
        bus.dsp_a      = acc ? bus.in_a : '0;
        bus.dsp_b      = acc ? bus.in_b : '0;
        // Stage 1 lines up with the slice OPMODE register: the first product starts from Z=0.
        bus.dsp_opmode = (vld_q[1] & fst_q[1]) ? 8'h01 : 8'h09;
        cnt_d          = acc ? (last_now ? '0 : cnt_q + 16'd1) : cnt_q;
        vld_d          = {vld_q[2:1], acc};
        fst_d          = {fst_q[2:1], acc & first_now};
        lst_d          = {lst_q[2:1], acc & last_now};
        push           = vld_q[3] & lst_q[3];
        pop            = bus.res_ready & (fcnt_q != '0);
        ovf_now        = (~fst_q[3] & ovf_q) | bus.dsp_carryout;
        ovf_d          = push ? 1'b0 : (vld_q[3] ? ovf_now : ovf_q);
        wr_d           = push ? wr_q + 1'b1 : wr_q;
        rd_d           = pop ? rd_q + 1'b1 : rd_q;
        fcnt_d         = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
        bus.res_valid  = fcnt_q != '0;
        bus.res_data   = bus.res_valid ? mem_data[rd_q] : '0;
        bus.res_ovf    = bus.res_valid & mem_ovf[rd_q];
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            vld_q  <= '0;
            fst_q  <= '0;
            lst_q  <= '0;
            ovf_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            fst_q  <= fst_d;
            lst_q  <= lst_d;
            ovf_q  <= ovf_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_q] <= bus.dsp_p;
            mem_ovf[wr_q]  <= ovf_now;
        end
    end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: directed and randomized checks of dsp_mac_seq against a dot-product scoreboard
// Ports: none; instantiates dsp_mac_seq_if, the DUT and a behavioural DSP slice model.
`timescale 1ns/1ps
module tb_dsp_mac_seq;
    localparam int LEN   = 4;
    localparam int DEPTH = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        pz       = 1'b0;
    logic        rr_rand  = 1'b0;
    int          cyc      = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          acc_total = 0, pop_cnt = 0, vld_cnt = 0, op01_cnt = 0;
    int          op01_cyc = 0, first_acc_cyc = 0, last_acc_cyc = 0, last_pop_cyc = 0;
    logic [48:0] exp_q [$];

    dsp_mac_seq_if bus();
    dsp_mac_seq #(.LEN(LEN), .RES_DEPTH(DEPTH)) dut (.clk(clk), .RST_N(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: A1/B1 -> M -> P registers, registered OPMODE and CARRYOUT.
    // pz marks a pair whose carry-out is forced high when it reaches P.
    logic        pz_in;
    logic [17:0] a1 = '0, b1 = '0;
    logic [35:0] m = '0;
    logic [47:0] p = '0;
    logic [7:0]  op_r = 8'h09;
    logic        co_r = 1'b0, pz1 = 1'b0, pzm = 1'b0, pzp = 1'b0;
    assign pz_in = pz & bus.in_valid & bus.in_ready;
    always @(posedge clk) begin
        a1   <= bus.dsp_a;
        b1   <= bus.dsp_b;
        pz1  <= pz_in;
        m    <= a1 * b1;
        pzm  <= pz1;
        op_r <= bus.dsp_opmode;
        {co_r, p} <= ((op_r[3:2] == 2'b10) ? {1'b0, p} : 49'd0) + {13'd0, m};
        pzp  <= pzm;
    end
    assign bus.dsp_p        = p;
    assign bus.dsp_carryout = co_r | pzp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: accumulate accepted pairs into LEN-element dots, compare every pop in order.
    int          k = 0;
    logic [47:0] sum = '0;
    logic        ovf = 1'b0;
    always @(negedge clk) begin
        logic [35:0] prod;
        logic [48:0] s;
        logic [48:0] e;
        if (!rst_n) begin
            k   = 0;
            sum = '0;
            ovf = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_total++;
                if (k == 0) first_acc_cyc = cyc;
                prod = bus.in_a * bus.in_b;
                s    = {1'b0, sum} + {13'd0, prod};
                ovf  = ovf | s[48] | pz;
                sum  = s[47:0];
                k++;
                if (k == LEN) begin
                    exp_q.push_back({ovf, sum});
                    last_acc_cyc = cyc;
                    k   = 0;
                    sum = '0;
                    ovf = 1'b0;
                end
            end
            if (bus.dsp_opmode == 8'h01) begin
                op01_cnt++;
                op01_cyc = cyc;
            end
            if (bus.res_valid) vld_cnt++;
            if (bus.res_valid && !bus.res_ready && exp_q.size() != 0) begin
                check("hold_data", bus.res_data, exp_q[0][47:0]);
                check("hold_ovf", bus.res_ovf, exp_q[0][48]);
            end
            if (bus.res_valid && bus.res_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                check("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("res_data", bus.res_data, e[47:0]);
                    check("res_ovf", bus.res_ovf, e[48]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic f, input int budget,
                        output logic ok);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        pz           = f;
        ok           = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        pz           = 1'b0;
    endtask

    task automatic put(input logic [17:0] a, input logic [17:0] b, input logic f);
        logic ok;
        send(a, b, f, 500, ok);
        check("accept", ok, 1);
    endtask

    task automatic drain();
        rr_rand       = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        check("drain_empty", exp_q.size(), 0);
        check("drain_valid", bus.res_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  a0, p0, v0, o0;
        logic ok;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_ovf", bus.res_ovf, 0);
        check("rst_dsp_a", bus.dsp_a, 0);
        check("rst_dsp_b", bus.dsp_b, 0);
        check("rst_opmode", bus.dsp_opmode, 8'h09);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", bus.in_ready, 1);

        // Back-to-back dot: 1*2+3*4+5*6+7*8 = 100, visible 4 cycles after the last accept.
        bus.res_ready = 1'b1;
        v0 = vld_cnt;
        put(18'd1, 18'd2, 1'b0);
        put(18'd3, 18'd4, 1'b0);
        put(18'd5, 18'd6, 1'b0);
        put(18'd7, 18'd8, 1'b0);
        repeat (8) tick();
        check("latency", last_pop_cyc - last_acc_cyc, 4);
        check("valid_cycles", vld_cnt - v0, 1);
        drain();

        // Same dot with 2-cycle gaps: a single Z=0 opmode, one cycle after the first accept.
        o0 = op01_cnt;
        for (int i = 0; i < LEN; i++) begin
            put(18'(2 * i + 1), 18'(2 * i + 2), 1'b0);
            repeat (2) tick();
        end
        drain();
        check("op01_count", op01_cnt - o0, 1);
        check("op01_cycle", op01_cyc - first_acc_cyc, 1);

        // Two dots back-to-back: 100 then 4.
        p0 = pop_cnt;
        for (int i = 0; i < LEN; i++) put(18'(2 * i + 1), 18'(2 * i + 2), 1'b0);
        for (int i = 0; i < LEN; i++) put(18'd1, 18'd1, 1'b0);
        drain();
        check("two_dots_pops", pop_cnt - p0, 2);

        // Backpressure: with no consumer the stream stalls once DEPTH results are committed.
        bus.res_ready = 1'b0;
        a0 = acc_total;
        p0 = pop_cnt;
        ok = 1'b1;
        for (int i = 0; i < 6 * LEN && ok; i++) send(18'd1, 18'd1, 1'b0, 40, ok);
        check("bp_accepted", acc_total - a0, (DEPTH - 1) * LEN + LEN - 1);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_no_pop", pop_cnt - p0, 0);
        bus.res_ready = 1'b1;
        while (acc_total - a0 < 6 * LEN) put(18'd1, 18'd1, 1'b0);
        drain();
        check("bp_pops", pop_cnt - p0, 6);

        // Forced carry-out on the 2nd element flags that dot only.
        p0 = pop_cnt;
        put(18'd1, 18'd1, 1'b0);
        put(18'd2, 18'd2, 1'b1);
        put(18'd3, 18'd3, 1'b0);
        put(18'd4, 18'd4, 1'b0);
        for (int i = 0; i < LEN; i++) put(18'd1, 18'd1, 1'b0);
        drain();
        check("ovf_pops", pop_cnt - p0, 2);

        // Reset mid-dot discards the partial sum.
        put(18'd9, 18'd9, 1'b0);
        put(18'd9, 18'd9, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < LEN; i++) put(18'(2 * i + 1), 18'(2 * i + 2), 1'b0);
        drain();
        check("rst_mid_pops", pop_cnt - p0, 1);

        // Random operands, gaps, consumer stalls and forced carries.
        p0 = pop_cnt;
        rr_rand = 1'b1;
        for (int d = 0; d < 25; d++) begin
            for (int e = 0; e < LEN; e++) begin
                repeat ($urandom_range(0, 2)) tick();
                put(18'($urandom), 18'($urandom), $urandom_range(0, 7) == 0);
            end
        end
        drain();
        check("rand_pops", pop_cnt - p0, 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
